// File: rtl/systolic_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// toy_tpu_pkg
// Shared types and constants for the TOY_TPU systolic sequencer.
//   seq_state_t : sequencer FSM states
//   TPU_K_W     : default width of the size and index fields
//   mm_cmd_t    : latched matrix-multiply sizes {r, c, k}
// Optional feature macro used by the sequencer files: TOY_TPU_ABORT_EN
// -----------------------------------------------------------------------------
package toy_tpu_pkg;

    localparam int TPU_K_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Field width is the package constant; the sequencer's K_W must equal it.
    typedef struct packed {
        logic [TPU_K_W-1:0] r;
        logic [TPU_K_W-1:0] c;
        logic [TPU_K_W-1:0] k;
    } mm_cmd_t;

endpackage

// File: rtl/systolic_sequencer_if.sv
// -----------------------------------------------------------------------------
// systolic_sequencer_if
// Command and array-control bundle of the systolic sequencer.
//   master : command source / array side (drives start + sizes, observes rest)
//   slave  : the sequencer itself
// Signals: start, size_row_A, size_column_B, size_columnrow_AB, busy, done,
//          err, array_reset, array_through, a_valid, a_k, b_valid, b_k,
//          drain_valid, drain_row; plus abort/aborted when TOY_TPU_ABORT_EN
//          is defined.
// -----------------------------------------------------------------------------
interface systolic_sequencer_if
    import toy_tpu_pkg::*;
#(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4,
    parameter int K_W           = TPU_K_W
);
    logic                         start;
    logic [K_W-1:0]               size_row_A;
    logic [K_W-1:0]               size_column_B;
    logic [K_W-1:0]               size_columnrow_AB;
    logic                         busy;
    logic                         done;
    logic                         err;
    logic                         array_reset;
    logic                         array_through;
    logic [ROW_NUMBER-1:0]        a_valid;
    logic [ROW_NUMBER*K_W-1:0]    a_k;
    logic [COLUMN_NUMBER-1:0]     b_valid;
    logic [COLUMN_NUMBER*K_W-1:0] b_k;
    logic                         drain_valid;
    logic [K_W-1:0]               drain_row;
`ifdef TOY_TPU_ABORT_EN
    logic                         abort;
    logic                         aborted;

    modport master (
        output start, size_row_A, size_column_B, size_columnrow_AB, abort,
        input  busy, done, err, array_reset, array_through, a_valid, a_k,
               b_valid, b_k, drain_valid, drain_row, aborted
    );
    modport slave (
        input  start, size_row_A, size_column_B, size_columnrow_AB, abort,
        output busy, done, err, array_reset, array_through, a_valid, a_k,
               b_valid, b_k, drain_valid, drain_row, aborted
    );
`else
    modport master (
        output start, size_row_A, size_column_B, size_columnrow_AB,
        input  busy, done, err, array_reset, array_through, a_valid, a_k,
               b_valid, b_k, drain_valid, drain_row
    );
    modport slave (
        input  start, size_row_A, size_column_B, size_columnrow_AB,
        output busy, done, err, array_reset, array_through, a_valid, a_k,
               b_valid, b_k, drain_valid, drain_row
    );
`endif
endinterface

// File: rtl/systolic_sequencer_lane.sv
// -----------------------------------------------------------------------------
// systolic_seq_lane
// One operand-fetch lane (A row or B column). For phase t, the lane is valid
// while LANE <= t <= LANE+K-1 and then fetches index t-LANE.
// Ports:
//   en    : lane is in use and the sequencer is feeding
//   t     : feed phase counter (K_W+2 bits)
//   k     : shared dimension K
//   valid : lane feed valid (combinational; registered by the top)
//   idx   : lane fetch index, 0 when not valid
// -----------------------------------------------------------------------------
module systolic_seq_lane #(
    parameter int LANE = 0,
    parameter int K_W  = 8
) (
    input  logic           en,
    input  logic [K_W+1:0] t,
    input  logic [K_W-1:0] k,
    output logic           valid,
    output logic [K_W-1:0] idx
);
    localparam logic [K_W+1:0] LANE_T = (K_W+2)'(LANE);

    logic [K_W+1:0] offset;

    // The subtraction only happens once t has reached the lane, so it never wraps.
    always_comb begin
        offset = '0;
        valid  = 1'b0;
        idx    = '0;
        if (en && (t >= LANE_T)) begin
            offset = t - LANE_T;
            if (offset < {2'b00, k}) begin
                valid = 1'b1;
                idx   = offset[K_W-1:0];
            end
        end
    end
endmodule

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Control sequencer for the TOY_TPU systolic array: IDLE -> CLEAR -> FEED ->
// DRAIN -> DONE -> IDLE. Generates skewed A/B fetch indices, the accumulator
// clear and the shift-out (through) window. All outputs are registered and
// are computed from the next-state values, so they line up with the state.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : systolic_sequencer_if.slave (command in, array control out)
// Optional: define TOY_TPU_ABORT_EN to add bus.abort / bus.aborted.
// -----------------------------------------------------------------------------
module systolic_sequencer
    import toy_tpu_pkg::*;
#(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4,
    parameter int K_W           = TPU_K_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    systolic_sequencer_if.slave   bus
);
    seq_state_t     state, state_next;
    logic [K_W+1:0] t, t_next;
    mm_cmd_t        cmd;
    logic           cmd_ok;
    logic           err_next;
    logic           clear_next;
    logic           abort_next;
    logic [K_W+1:0] feed_last;
    logic [K_W+1:0] drain_last;
    logic           feed_next;

    logic [ROW_NUMBER-1:0]        a_valid_c;
    logic [ROW_NUMBER*K_W-1:0]    a_k_c;
    logic [COLUMN_NUMBER-1:0]     b_valid_c;
    logic [COLUMN_NUMBER*K_W-1:0] b_k_c;

    assign cmd_ok = (bus.size_row_A != '0) && (bus.size_row_A <= K_W'(ROW_NUMBER)) &&
                    (bus.size_column_B != '0) && (bus.size_column_B <= K_W'(COLUMN_NUMBER)) &&
                    (bus.size_columnrow_AB != '0);

    assign feed_last  = {2'b00, cmd.k} + {2'b00, cmd.r} + {2'b00, cmd.c} - (K_W+2)'(2);
    assign drain_last = {2'b00, cmd.r} - (K_W+2)'(1);
    assign feed_next  = (state_next == ST_FEED);

    // ---- next-state logic ----
    always_comb begin
        state_next = state;
        t_next     = t;
        err_next   = 1'b0;
        clear_next = 1'b0;
        abort_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (cmd_ok) begin
                        state_next = ST_CLEAR;
                        clear_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_next = ST_FEED;
                t_next     = '0;
            end
            ST_FEED: begin
                if (t == feed_last) begin
                    state_next = ST_DRAIN;
                    t_next     = '0;
                end else begin
                    t_next = t + (K_W+2)'(1);
                end
            end
            ST_DRAIN: begin
                if (t == drain_last) state_next = ST_DONE;
                else                 t_next     = t + (K_W+2)'(1);
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
`ifdef TOY_TPU_ABORT_EN
        // Abort wins over the normal transition and re-clears the array.
        if (bus.abort && (state inside {ST_CLEAR, ST_FEED, ST_DRAIN})) begin
            state_next = ST_IDLE;
            t_next     = '0;
            clear_next = 1'b1;
            abort_next = 1'b1;
        end
`endif
    end

    // ---- lane comparators ----
    for (genvar i = 0; i < ROW_NUMBER; i++) begin : g_a_lane
        systolic_seq_lane #(.LANE(i), .K_W(K_W)) u_lane (
            .en    (feed_next && (K_W'(i) < cmd.r)),
            .t     (t_next),
            .k     (cmd.k),
            .valid (a_valid_c[i]),
            .idx   (a_k_c[i*K_W +: K_W])
        );
    end

    for (genvar j = 0; j < COLUMN_NUMBER; j++) begin : g_b_lane
        systolic_seq_lane #(.LANE(j), .K_W(K_W)) u_lane (
            .en    (feed_next && (K_W'(j) < cmd.c)),
            .t     (t_next),
            .k     (cmd.k),
            .valid (b_valid_c[j]),
            .idx   (b_k_c[j*K_W +: K_W])
        );
    end

    // ---- command latch ----
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && bus.start) begin
            cmd.r <= bus.size_row_A;
            cmd.c <= bus.size_column_B;
            cmd.k <= bus.size_columnrow_AB;
        end
    end

    // ---- state and output registers ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            t                 <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.err           <= 1'b0;
            bus.array_reset   <= 1'b0;
            bus.array_through <= 1'b0;
            bus.drain_valid   <= 1'b0;
            bus.drain_row     <= '0;
            bus.a_valid       <= '0;
            bus.a_k           <= '0;
            bus.b_valid       <= '0;
            bus.b_k           <= '0;
`ifdef TOY_TPU_ABORT_EN
            bus.aborted       <= 1'b0;
`endif
        end else begin
            state             <= state_next;
            t                 <= t_next;
            bus.busy          <= (state_next != ST_IDLE);
            bus.done          <= (state_next == ST_DONE);
            bus.err           <= err_next;
            bus.array_reset   <= clear_next;
            bus.array_through <= (state_next == ST_DRAIN);
            bus.drain_valid   <= (state_next == ST_DRAIN);
            // Bottom row leaves the array first.
            bus.drain_row     <= (state_next == ST_DRAIN) ?
                                 (cmd.r - K_W'(1) - t_next[K_W-1:0]) : '0;
            bus.a_valid       <= a_valid_c;
            bus.a_k           <= a_k_c;
            bus.b_valid       <= b_valid_c;
            bus.b_k           <= b_k_c;
`ifdef TOY_TPU_ABORT_EN
            bus.aborted       <= abort_next;
`endif
        end
    end

`ifndef TOY_TPU_ABORT_EN
    logic unused_abort;
    assign unused_abort = abort_next;
`endif
endmodule
